dft_crm_div_ctrl: RTL and testbench

Run-time ratio controller for the CRM clock divider. It accepts a new divide ratio from a config requester, waits for the divider's end-of-period point, and gates the divided clock for a settle window. It then loads the new ratio with a divider restart pulse, ungates, and acknowledges the requester. In DFT test mode it is frozen with the clock enabled, so the divider's test bypass is never gated.

---
 rtl/dft_crm_pkg.sv | 20 ++
 rtl/dft_crm_cnt_tmr.sv | 30 +++
 rtl/dft_crm_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_dft_crm_div_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dft_crm_pkg.sv
// Shared types for the CRM divider ratio controller.
//   crm_state_e : sequencing states of the ratio-change controller
//   cnt_w()     : width needed to hold a down-count starting at n-1
package dft_crm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WRAP,
    GATE,
    LOAD,
    UNGATE,
    ACK
  } crm_state_e;

  // Bits needed to hold n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dft_crm_cnt_tmr.sv
// Loadable down-counter with a done flag.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this edge (takes priority over en)
//   en         : decrement by one, saturating at zero
//   load_val   : value loaded on load
//   done       : count is zero
// Loading n-1 on the edge that enters a state gives done in the n-th
// cycle spent in that state.
module dft_crm_cnt_tmr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dft_crm_div_ctrl.sv
// Run-time ratio controller for the CRM clock divider.
// A ratio change waits for the divider's end-of-period (or a timeout),
// gates the divided clock for a settle window, loads the new ratio with a
// restart pulse, holds the gate for a second settle window, then ungates
// and acknowledges. DFT test mode freezes the controller with the divided
// clock enabled.
//   clk, rst_n   : source clock, async active-low reset
//   test_mode    : DFT test mode, forces IDLE with the clock ungated
//   cfg_req/div  : single-cycle ratio change request and requested ratio
//   cfg_ack      : pulse, new ratio in effect
//   cfg_busy     : sequence in progress
//   cfg_err      : pulse, request rejected (zero ratio or busy)
//   cfg_tmo      : sticky, last sequence proceeded without seeing a wrap
//   div_wrap     : divider end-of-period pulse
//   div_ratio    : ratio driven to the divider
//   div_clk_en   : divided-clock gate enable
//   div_restart  : pulse, divider counters restart
module dft_crm_div_ctrl
  import dft_crm_pkg::*;
#(
  parameter int DIV_W      = 4,
  parameter int DEF_DIV    = 3,
  parameter int SETTLE_CYC = 4,
  parameter int TMO_CYC    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_mode,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic             cfg_tmo,
  input  logic             div_wrap,
  output logic [DIV_W-1:0] div_ratio,
  output logic             div_clk_en,
  output logic             div_restart
);

  localparam int WAIT_W = DIV_W + 2;
  localparam int SET_W  = cnt_w(SETTLE_CYC);

  crm_state_e       state;
  logic [DIV_W-1:0] new_div;
  logic             wait_done, settle_done;
  logic             start_seq, wait_exit;
  logic             wait_ld, settle_ld;

  // A request that actually starts a gating sequence.
  assign start_seq = !test_mode && state == IDLE && cfg_req &&
                     cfg_div != '0 && cfg_div != div_ratio;
  assign wait_exit = state == WAIT_WRAP && (div_wrap || wait_done);

  // Counters are loaded on the same edge that enters the state they time.
  assign wait_ld   = start_seq;
  assign settle_ld = !test_mode && (wait_exit || state == LOAD);

  dft_crm_cnt_tmr #(.W(WAIT_W)) u_wait_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wait_ld),
    .en       (state == WAIT_WRAP),
    .load_val (WAIT_W'(TMO_CYC - 1)),
    .done     (wait_done)
  );

  dft_crm_cnt_tmr #(.W(SET_W)) u_settle_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_ld),
    .en       (state == GATE || state == UNGATE),
    .load_val (SET_W'(SETTLE_CYC - 1)),
    .done     (settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      new_div     <= DIV_W'(DEF_DIV);
      div_ratio   <= DIV_W'(DEF_DIV);
      div_clk_en  <= 1'b1;
      div_restart <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_busy    <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_tmo     <= 1'b0;
    end else begin
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
      div_restart <= 1'b0;
      if (test_mode) begin
        // Freeze ungated; div_ratio keeps whatever was last loaded.
        state      <= IDLE;
        div_clk_en <= 1'b1;
        cfg_busy   <= 1'b0;
      end else begin
        // Requests outside IDLE are rejected without disturbing the sequence.
        if (cfg_req && state != IDLE) cfg_err <= 1'b1;
        case (state)
          IDLE: if (cfg_req) begin
            if (cfg_div == '0) begin
              cfg_err <= 1'b1;
            end else if (cfg_div == div_ratio) begin
              state    <= ACK;
              cfg_ack  <= 1'b1;
              cfg_busy <= 1'b1;
            end else begin
              new_div  <= cfg_div;
              cfg_tmo  <= 1'b0;
              cfg_busy <= 1'b1;
              state    <= WAIT_WRAP;
            end
          end
          WAIT_WRAP: if (wait_exit) begin
            state      <= GATE;
            div_clk_en <= 1'b0;
            // A wrap in the timeout cycle still counts as a clean wrap.
            if (!div_wrap) cfg_tmo <= 1'b1;
          end
          GATE: if (settle_done) begin
            state       <= LOAD;
            div_restart <= 1'b1;
          end
          LOAD: begin
            div_ratio <= new_div;
            state     <= UNGATE;
          end
          UNGATE: if (settle_done) begin
            state      <= ACK;
            cfg_ack    <= 1'b1;
            div_clk_en <= 1'b1;
          end
          ACK: begin
            state    <= IDLE;
            cfg_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dft_crm_div_ctrl.sv
module tb_dft_crm_div_ctrl;

  localparam int DIV_W   = 4;
  localparam int DEF_DIV = 3;
  localparam int S       = 4;
  localparam int TMO     = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             test_mode = 1'b0;
  logic             cfg_req = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             div_wrap = 1'b0;
  logic             cfg_ack, cfg_busy, cfg_err, cfg_tmo;
  logic             div_clk_en, div_restart;
  logic [DIV_W-1:0] div_ratio;

  int   ntests = 0;
  int   nfail  = 0;
  logic [3:0] m_ratio;
  logic       m_tmo;

  always #5 clk = ~clk;

  dft_crm_div_ctrl #(
    .DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .SETTLE_CYC(S), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_mode(test_mode),
    .cfg_req(cfg_req), .cfg_div(cfg_div),
    .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .cfg_err(cfg_err), .cfg_tmo(cfg_tmo),
    .div_wrap(div_wrap), .div_ratio(div_ratio),
    .div_clk_en(div_clk_en), .div_restart(div_restart)
  );

  // Expected-output vector: {ack, busy, err, tmo, clk_en, restart, ratio}
  function automatic logic [9:0] pk(input logic ack, input logic busy,
                                    input logic err, input logic tmo,
                                    input logic en, input logic rs,
                                    input logic [3:0] r);
    return {ack, busy, err, tmo, en, rs, r};
  endfunction

  task automatic chk(input string tag, input int k, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {cfg_ack, cfg_busy, cfg_err, cfg_tmo, div_clk_en, div_restart, div_ratio};
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, i, pk(0, 0, 0, m_tmo, 1, 0, m_ratio));
      nxt();
    end
  endtask

  // Ratio change sequence starting at the current cycle (k=0 is the request).
  // d : cycle offset of the wrap pulse, 0 = never (timeout path)
  // req2 : offset of an extra request while busy, -1 = none
  // n_k : stop after this many cycles (model left untouched), -1 = full run
  // The expected timeline comes straight from the latency rules: wrap seen
  // at W, gate low W+1..W+2S+1, restart W+S+1, ack W+2S+2.
  task automatic run_seq(input string tag, input logic [3:0] nd, input int d,
                         input int req2, input int n_k);
    bit         to;
    int         w, last;
    logic [3:0] old;
    logic       old_tmo;
    to      = (d == 0);
    w       = to ? TMO : d;
    old     = m_ratio;
    old_tmo = m_tmo;
    last    = (n_k < 0) ? w + 2*S + 3 : n_k - 1;
    for (int k = 0; k <= last; k++) begin
      cfg_req = (k == 0) || (k == req2);
      cfg_div = (k == 0) ? nd : 4'($urandom);
      if (k >= 1 && k <= w) div_wrap = (!to && k == w);
      else                  div_wrap = 1'($urandom);
      @(negedge clk);
      chk(tag, k, pk(k == w + 2*S + 2,
                     k >= 1 && k <= w + 2*S + 2,
                     req2 >= 0 && k == req2 + 1,
                     (k == 0) ? old_tmo : (to && k >= w + 1),
                     !(k >= w + 1 && k <= w + 2*S + 1),
                     k == w + S + 1,
                     (k >= w + S + 2) ? nd : old));
      nxt();
    end
    cfg_req  = 1'b0;
    div_wrap = 1'b0;
    if (n_k < 0) begin
      m_ratio = nd;
      m_tmo   = to;
    end
  endtask

  initial begin
    logic [3:0] nd;
    int         d, r2;

    // Reset state
    m_ratio = 4'(DEF_DIV);
    m_tmo   = 1'b0;
    @(negedge clk);
    chk("reset", 0, pk(0, 0, 0, 0, 1, 0, 4'(DEF_DIV)));
    nxt();
    rst_n = 1'b1;
    idle_chk("idle_after_reset", 10);

    // Wrap three cycles after the request: gate N+4..N+12, ack N+13
    run_seq("seq_5_w3", 4'd5, 3, -1, -1);

    // Same ratio: immediate ack, no gating
    cfg_req = 1'b1; cfg_div = m_ratio;
    @(negedge clk); chk("same_req", 0, pk(0, 0, 0, m_tmo, 1, 0, m_ratio));
    nxt(); cfg_req = 1'b0;
    @(negedge clk); chk("same_ack", 1, pk(1, 1, 0, m_tmo, 1, 0, m_ratio));
    nxt();
    idle_chk("same_after", 2);

    // Zero ratio: rejected, ratio unchanged
    cfg_req = 1'b1; cfg_div = 4'd0;
    nxt(); cfg_req = 1'b0;
    @(negedge clk); chk("zero_err", 1, pk(0, 0, 1, m_tmo, 1, 0, m_ratio));
    nxt();
    idle_chk("zero_after", 2);

    // No wrap: timeout after 32 waiting cycles, sticky tmo
    run_seq("seq_7_tmo", 4'd7, 0, -1, -1);
    idle_chk("tmo_sticky", 2);

    // Same-ratio ack leaves tmo alone
    cfg_req = 1'b1; cfg_div = m_ratio;
    nxt(); cfg_req = 1'b0;
    @(negedge clk); chk("same_keep_tmo", 1, pk(1, 1, 0, m_tmo, 1, 0, m_ratio));
    nxt();
    idle_chk("same_keep_after", 1);

    // Extra request during GATE (k=4 with wrap at 2): err, first sequence wins
    run_seq("seq_busy_gate", 4'd12, 2, 4, -1);

    // Randomized sequences
    for (int i = 0; i < 6; i++) begin
      do nd = 4'($urandom_range(1, 15)); while (nd == m_ratio);
      d  = $urandom_range(1, 20);
      r2 = $urandom_range(0, 1) ? $urandom_range(1, d + 2*S + 2) : -1;
      run_seq("seq_rand", nd, d, r2, -1);
      idle_chk("rand_gap", $urandom_range(1, 3));
    end

    // test_mode raised in GATE: forced idle, ratio unchanged, no ack
    do nd = 4'($urandom_range(1, 15)); while (nd == m_ratio);
    run_seq("tm_pre", nd, 1, -1, 3);
    test_mode = 1'b1;
    @(negedge clk); chk("tm_gate", 3, pk(0, 1, 0, 0, 0, 0, m_ratio));
    nxt();
    cfg_req = 1'b1; cfg_div = nd;
    @(negedge clk); chk("tm_forced", 4, pk(0, 0, 0, 0, 1, 0, m_ratio));
    nxt(); cfg_req = 1'b0;
    m_tmo = 1'b0;
    idle_chk("tm_hold", 4);
    test_mode = 1'b0;
    idle_chk("tm_release", 3);

    // Reset asserted during UNGATE (k=8 with wrap at 1)
    do nd = 4'($urandom_range(1, 15)); while (nd == m_ratio || nd == 4'(DEF_DIV));
    run_seq("rst_pre", nd, 1, -1, 8);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 8, pk(0, 0, 0, 0, 1, 0, 4'(DEF_DIV)));
    @(negedge clk); chk("rst_hold", 8, pk(0, 0, 0, 0, 1, 0, 4'(DEF_DIV)));
    nxt();
    rst_n   = 1'b1;
    m_ratio = 4'(DEF_DIV);
    m_tmo   = 1'b0;
    idle_chk("rst_after", 4);

    // Normal operation after reset
    run_seq("seq_post_rst", 4'd9, 5, -1, -1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
